clock_div_bank: RTL and testbench

- Parametrised, runtime-programmable bank of clock dividers; successor to the fixed-ratio clock generator.
- Each of NUM_CH channels divides clkIn by its own divisor, which is written at runtime.
- Per channel: a registered divided clock, a one-cycle tick strobe for use as a clock enable, and a pending-update flag.
- Divisor changes take effect only at period boundaries (glitch-free); a global sync input phase-aligns all channels.

---
 rtl/clock_div_bank.sv | 111 +++++++++++
 tb/tb_clock_div_bank.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_bank.sv
// Bank of runtime-programmable clock dividers with registered clocks, tick strobes
// and glitch-free divisor updates applied only at period boundaries.
module clock_div_bank #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic              clkIn,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend,
    output logic              cfg_err
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    logic w_wr_ok;
    logic w_wr_bad;
    logic r_cfg_err;

    always_comb begin
        w_wr_ok  = wr_en && (32'(wr_ch) < NUM_CH) && (wr_div >= TWO);
        w_wr_bad = wr_en && !w_wr_ok;
    end

    // Sticky illegal-write flag, cleared only by reset
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else if (w_wr_bad) begin
            r_cfg_err <= 1'b1;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_pdiv;
        logic             r_pend;
        logic             r_clk;
        logic             r_tick;

        logic [DIV_W-1:0] w_cnt_n;
        logic [DIV_W-1:0] w_div_n;
        logic [DIV_W-1:0] w_pdiv_n;
        logic             w_pend_n;
        logic             w_hit;
        logic             w_wrap;
        logic             w_restart;
        logic             w_apply;

        // A pending divisor lands on a wrap or sync edge, or at once while disabled;
        // a write on that same edge is queued behind it for the next boundary.
        always_comb begin
            w_cnt_n   = r_cnt;
            w_div_n   = r_div;
            w_pdiv_n  = r_pdiv;
            w_pend_n  = r_pend;
            w_hit     = w_wr_ok && (wr_ch == CH_W'(g));
            w_wrap    = (r_cnt == (r_div - ONE));
            w_restart = ch_en[g] && (sync || w_wrap);
            w_apply   = r_pend && (!ch_en[g] || w_restart);
            if (w_apply) begin
                w_div_n = r_pdiv;
            end
            if (ch_en[g]) begin
                w_cnt_n = w_restart ? '0 : (r_cnt + ONE);
            end else begin
                w_cnt_n = w_div_n - ONE;
            end
            w_pend_n = w_hit || (r_pend && !w_apply);
            if (w_hit) begin
                w_pdiv_n = wr_div;
            end
        end

        always_ff @(posedge clkIn or posedge rst) begin
            if (rst) begin
                r_cnt  <= DEF_DIV - ONE;
                r_div  <= DEF_DIV;
                r_pdiv <= DEF_DIV;
                r_pend <= 1'b0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_n;
                r_div  <= w_div_n;
                r_pdiv <= w_pdiv_n;
                r_pend <= w_pend_n;
                r_clk  <= ch_en[g] && (w_cnt_n < (w_div_n >> 1));
                r_tick <= ch_en[g] && (w_cnt_n == '0);
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
        assign pend[g]    = r_pend;
    end

endmodule

// File: tb/tb_clock_div_bank.sv
// Directed bench for clock_div_bank: default ratio, writes, errors, sync, enable and reset.
module tb_clock_div_bank;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned DIV_W  = 8;

    logic              clkIn;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [DIV_W-1:0]  wr_div;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;
    logic              cfg_err;

    int errors;
    int checks;

    clock_div_bank #(
        .NUM_CH     (NUM_CH),
        .CH_W       (CH_W),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(4)
    ) dut (
        .clkIn  (clkIn),
        .rst    (rst),
        .ch_en  (ch_en),
        .sync   (sync),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .clk_out(clk_out),
        .tick   (tick),
        .pend   (pend),
        .cfg_err(cfg_err)
    );

    initial begin
        clkIn = 1'b0;
        forever #5 clkIn = ~clkIn;
    end

    // Expected divided-clock level j cycles into a period of length d
    function automatic logic hi(input int j, input int d);
        return (j % d) < (d / 2);
    endfunction

    function automatic logic tk(input int j, input int d);
        return (j % d) == 0;
    endfunction

    task automatic step();
        @(posedge clkIn);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ch_en  = '1;
        sync   = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
        repeat (5) @(negedge clkIn);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        ch_en  = '1;
        sync   = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
        #12;
        checks++;
        if ({clk_out, tick, pend} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=000", {clk_out, tick, pend});
        end
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_cfg_err got=%b want=0", cfg_err);
        end
        repeat (4) @(negedge clkIn);
        rst = 1'b0;
        step();
        checks++;
        if ({clk_out, tick} !== 8'hFF) begin
            errors++;
            $display("FAIL first_edge got=%h want=ff", {clk_out, tick});
        end
    endtask

    task automatic test_default();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if ({clk_out, tick} !== {{4{hi(k, 4)}}, {4{tk(k, 4)}}}) begin
                errors++;
                $display("FAIL default k=%0d got=%h want=%h", k, {clk_out, tick},
                         {{4{hi(k, 4)}}, {4{tk(k, 4)}}});
            end
        end
    endtask

    task automatic test_write();
        logic [3:0] ec;
        logic [3:0] et;
        logic [3:0] ep;
        do_reset();
        step();
        step();
        wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd5;
        for (int k = 2; k < 24; k++) begin
            step();
            wr_en = 1'b0;
            ec = {4{hi(k, 4)}};
            et = {4{tk(k, 4)}};
            if (k >= 4) begin
                ec[1] = hi(k - 4, 5);
                et[1] = tk(k - 4, 5);
            end
            ep = (k < 4) ? 4'b0010 : 4'b0000;
            checks++;
            if ({clk_out, tick, pend} !== {ec, et, ep}) begin
                errors++;
                $display("FAIL write_div5 k=%0d got=%h want=%h", k, {clk_out, tick, pend}, {ec, et, ep});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ec;
        do_reset();
        step();
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd3;
        step();
        wr_div = 8'd6;
        step();
        wr_en = 1'b0;
        for (int k = 3; k < 22; k++) begin
            step();
            ec = {4{hi(k, 4)}};
            if (k >= 4) ec[0] = hi(k - 4, 6);
            checks++;
            if (clk_out !== ec) begin
                errors++;
                $display("FAIL last_write_wins k=%0d got=%h want=%h", k, clk_out, ec);
            end
        end
    endtask

    task automatic test_cfg_err();
        do_reset();
        step();
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd1;
        step();
        wr_ch = 3'd4; wr_div = 8'd6;
        checks++;
        if ({cfg_err, pend} !== 5'b10000) begin
            errors++;
            $display("FAIL err_div1 got=%b want=10000", {cfg_err, pend});
        end
        step();
        wr_en = 1'b0;
        for (int k = 3; k < 23; k++) begin
            step();
            checks++;
            if ({cfg_err, pend, clk_out} !== {1'b1, 4'b0000, {4{hi(k, 4)}}}) begin
                errors++;
                $display("FAIL err_hold k=%0d got=%h want=%h", k, {cfg_err, pend, clk_out},
                         {1'b1, 4'b0000, {4{hi(k, 4)}}});
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got=%b want=0", cfg_err);
        end
    endtask

    task automatic test_sync();
        logic [3:0] ec;
        logic [3:0] et;
        do_reset();
        wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd6;
        for (int k = 0; k < 31; k++) begin
            step();
            wr_en = 1'b0;
            sync  = (k == 6);
            if (k < 7) begin
                ec = {4{hi(k, 4)}};
                et = {4{tk(k, 4)}};
                if (k >= 4) begin
                    ec[1] = hi(k - 4, 6);
                    et[1] = tk(k - 4, 6);
                end
            end else begin
                ec = {4{hi(k - 7, 4)}};
                et = {4{tk(k - 7, 4)}};
                ec[1] = hi(k - 7, 6);
                et[1] = tk(k - 7, 6);
            end
            checks++;
            if ({clk_out, tick} !== {ec, et}) begin
                errors++;
                $display("FAIL sync k=%0d got=%h want=%h", k, {clk_out, tick}, {ec, et});
            end
        end
        sync = 1'b0;
    endtask

    task automatic test_enable();
        logic [3:0] ec;
        logic [3:0] et;
        do_reset();
        step();
        ch_en = 4'b1011;
        for (int k = 1; k < 14; k++) begin
            step();
            ch_en = (k >= 5) ? 4'b1111 : 4'b1011;
            ec = {4{hi(k, 4)}};
            et = {4{tk(k, 4)}};
            ec[2] = (k < 6) ? 1'b0 : hi(k - 6, 4);
            et[2] = (k < 6) ? 1'b0 : tk(k - 6, 4);
            checks++;
            if ({clk_out, tick} !== {ec, et}) begin
                errors++;
                $display("FAIL enable k=%0d got=%h want=%h", k, {clk_out, tick}, {ec, et});
            end
        end
        do_reset();
        wr_en = 1'b1; wr_ch = 3'd3; wr_div = 8'd255;
        for (int k = 0; k < 4; k++) begin
            step();
            wr_en = 1'b0;
        end
        for (int j = 0; j < 510; j++) begin
            step();
            checks++;
            if ({clk_out[3], tick[3]} !== {hi(j, 255), tk(j, 255)}) begin
                errors++;
                $display("FAIL div255 j=%0d got=%b want=%b", j, {clk_out[3], tick[3]},
                         {hi(j, 255), tk(j, 255)});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step();
        wr_en = 1'b1; wr_ch = 3'd2; wr_div = 8'd7;
        step();
        wr_en = 1'b0;
        checks++;
        if ({clk_out, pend} !== 8'hF4) begin
            errors++;
            $display("FAIL pre_reset got=%h want=f4", {clk_out, pend});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({clk_out, tick, pend} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset got=%h want=000", {clk_out, tick, pend});
        end
        repeat (5) @(negedge clkIn);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if ({clk_out, tick, pend} !== {{4{hi(k, 4)}}, {4{tk(k, 4)}}, 4'b0000}) begin
                errors++;
                $display("FAIL after_reset k=%0d got=%h want=%h", k, {clk_out, tick, pend},
                         {{4{hi(k, 4)}}, {4{tk(k, 4)}}, 4'b0000});
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_default();
        test_write();
        test_back_to_back();
        test_cfg_err();
        test_sync();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
